// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU commands,
// instruction field positions and the ID/EXE bundle.
package id_stage_pkg;

  localparam int DW      = 32;
  localparam int REG_CNT = 32;
  localparam int RW      = $clog2(REG_CNT);

  localparam logic [31:0] NOP = 32'h0;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_NOR  = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_SLA  = 6'b001001;
  localparam logic [5:0] OP_SLL  = 6'b001010;
  localparam logic [5:0] OP_SRA  = 6'b001011;
  localparam logic [5:0] OP_SRL  = 6'b001100;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b100101;
  localparam logic [5:0] OP_BEZ  = 6'b101000;
  localparam logic [5:0] OP_BNE  = 6'b101001;
  localparam logic [5:0] OP_JMP  = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0011;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [3:0]    alu_cmd;
    logic [DW-1:0] val1;
    logic [DW-1:0] val2;
    logic [DW-1:0] st_val;
    logic [RW-1:0] dest;
    logic          wb_en;
    logic          mem_r;
    logic          mem_w;
  } id_ex_t;

  function automatic logic [DW-1:0] sext16(input logic [15:0] v);
    return {{(DW-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID, write-back, hazard-source and ID/EXE signals of the ID stage.
interface id_stage_if;
  import id_stage_pkg::*;

  logic [DW-1:0] pc_in;
  logic [DW-1:0] instr_in;
  logic          wb_en;
  logic [RW-1:0] wb_dest;
  logic [DW-1:0] wb_val;
  logic          exe_wb_en;
  logic [RW-1:0] exe_dest;
  logic          mem_wb_en;
  logic [RW-1:0] mem_dest;
  logic          freez;
  logic          br_taken;
  logic [DW-1:0] br_addr;
  logic [DW-1:0] pc_out;
  logic [3:0]    alu_cmd;
  logic [DW-1:0] val1;
  logic [DW-1:0] val2;
  logic [DW-1:0] st_val;
  logic [RW-1:0] dest;
  logic          wb_en_out;
  logic          mem_r;
  logic          mem_w;

  modport master (
    output pc_in, instr_in, wb_en, wb_dest, wb_val,
    output exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    input  freez, br_taken, br_addr, pc_out, alu_cmd,
    input  val1, val2, st_val, dest, wb_en_out,
    input  mem_r, mem_w
  );

  modport slave (
    input  pc_in, instr_in, wb_en, wb_dest, wb_val,
    input  exe_wb_en, exe_dest, mem_wb_en, mem_dest,
    output freez, br_taken, br_addr, pc_out, alu_cmd,
    output val1, val2, st_val, dest, wb_en_out,
    output mem_r, mem_w
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// Register file: 2 combinational read ports with write-through,
// 1 write port, r0 hardwired to zero.
module id_stage_reg_file #(
  parameter  int REG_CNT = 32,
  parameter  int DW      = 32,
  localparam int AW      = $clog2(REG_CNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs [REG_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0)           ? '0 :
               (we && wa == ra1)     ? wd :
                                       regs[ra1];
  assign rd2 = (ra2 == '0)           ? '0 :
               (we && wa == ra2)     ? wd :
                                       regs[ra2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, RAW hazard stall, branch
// resolution and the ID/EXE pipeline register.
module id_stage
  import id_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [5:0]    op;
  logic [RW-1:0] rs, rt, rd;
  logic [DW-1:0] imm, rv1, rv2;
  logic          is_r, is_ai, is_ld, is_st;
  logic          is_bez, is_bne, is_jmp;
  logic          use1, use2, br_cond;
  logic          haz1, haz2, freez;
  id_ex_t        d, q;

  assign op  = bus.instr_in[OP_LSB +: 6];
  assign rs  = bus.instr_in[RS_LSB +: RW];
  assign rt  = bus.instr_in[RT_LSB +: RW];
  assign rd  = bus.instr_in[RD_LSB +: RW];
  assign imm = sext16(bus.instr_in[15:0]);

  id_stage_reg_file #(
    .REG_CNT(REG_CNT),
    .DW     (DW)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .ra1(rs),
    .ra2(rt),
    .rd1(rv1),
    .rd2(rv2),
    .we (bus.wb_en),
    .wa (bus.wb_dest),
    .wd (bus.wb_val)
  );

  always_comb begin
    is_r   = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR,
                        OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL};
    is_ai  = op inside {OP_ADDI, OP_SUBI};
    is_ld  = (op == OP_LD);
    is_st  = (op == OP_ST);
    is_bez = (op == OP_BEZ);
    is_bne = (op == OP_BNE);
    is_jmp = (op == OP_JMP);
    d       = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    br_cond = 1'b0;
    unique case (1'b1)
      is_r: begin
        use1      = 1'b1;
        use2      = 1'b1;
        // R-type opcodes carry their ALU command in the low nibble
        d.alu_cmd = op[3:0];
        d.pc      = bus.pc_in;
        d.val1    = rv1;
        d.val2    = rv2;
        d.dest    = rd;
        d.wb_en   = 1'b1;
      end
      is_ai, is_ld: begin
        use1      = 1'b1;
        d.alu_cmd = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
        d.pc      = bus.pc_in;
        d.val1    = rv1;
        d.val2    = imm;
        d.dest    = rt;
        d.wb_en   = 1'b1;
        d.mem_r   = is_ld;
      end
      is_st: begin
        use1      = 1'b1;
        use2      = 1'b1;
        d.alu_cmd = ALU_ADD;
        d.pc      = bus.pc_in;
        d.val1    = rv1;
        d.val2    = imm;
        d.st_val  = rv2;
        d.mem_w   = 1'b1;
      end
      is_bez: begin
        use1    = 1'b1;
        br_cond = (rv1 == '0);
      end
      is_bne: begin
        use1    = 1'b1;
        use2    = 1'b1;
        br_cond = (rv1 != rv2);
      end
      is_jmp: br_cond = 1'b1;
      default: ;
    endcase
  end

  assign haz1 = (rs != '0) &&
                ((bus.exe_wb_en && rs == bus.exe_dest) ||
                 (bus.mem_wb_en && rs == bus.mem_dest));
  assign haz2 = (rt != '0) &&
                ((bus.exe_wb_en && rt == bus.exe_dest) ||
                 (bus.mem_wb_en && rt == bus.mem_dest));
  assign freez = (use1 && haz1) || (use2 && haz2);

  assign bus.freez    = freez;
  assign bus.br_taken = br_cond && !freez;
  assign bus.br_addr  = bus.pc_in + {imm[DW-3:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (freez) q <= '0;
    else            q <= d;
  end

  assign bus.pc_out    = q.pc;
  assign bus.alu_cmd   = q.alu_cmd;
  assign bus.val1      = q.val1;
  assign bus.val2      = q.val2;
  assign bus.st_val    = q.st_val;
  assign bus.dest      = q.dest;
  assign bus.wb_en_out = q.wb_en;
  assign bus.mem_r     = q.mem_r;
  assign bus.mem_w     = q.mem_w;

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage plus hand-written reset
// and write-through sequences.
module tb_id_stage;
  import id_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  id_stage_if bus();

  id_stage u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb;
    logic [4:0]  wbd;
    logic [31:0] wbv;
    logic        ex;
    logic [4:0]  exd;
    logic        mw;
    logic [4:0]  md;
    logic        fz;
    logic        bt;
    logic [31:0] ba;
    logic [3:0]  alu;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] sv;
    logic [31:0] pco;
    logic [4:0]  dst;
    logic        wbo;
    logic        mr;
    logic        mwr;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic logic [31:0] enc_r(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] dd);
    return {op, s, t, dd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.instr_in  = v.instr;
    bus.pc_in     = v.pc;
    bus.wb_en     = v.wb;
    bus.wb_dest   = v.wbd;
    bus.wb_val    = v.wbv;
    bus.exe_wb_en = v.ex;
    bus.exe_dest  = v.exd;
    bus.mem_wb_en = v.mw;
    bus.mem_dest  = v.md;
  endtask

  task automatic chk_regs(input string p, input vec_t v);
    chk({p, " alu_cmd"},   32'(bus.alu_cmd),   32'(v.alu));
    chk({p, " val1"},      bus.val1,           v.v1);
    chk({p, " val2"},      bus.val2,           v.v2);
    chk({p, " st_val"},    bus.st_val,         v.sv);
    chk({p, " pc_out"},    bus.pc_out,         v.pco);
    chk({p, " dest"},      32'(bus.dest),      32'(v.dst));
    chk({p, " wb_en_out"}, 32'(bus.wb_en_out), 32'(v.wbo));
    chk({p, " mem_r"},     32'(bus.mem_r),     32'(v.mr));
    chk({p, " mem_w"},     32'(bus.mem_w),     32'(v.mwr));
  endtask

  initial begin
    vec_t z;
    vec_t xv;
    logic [31:0] bne_i;
    logic [31:0] add_i;
    z = '{32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0,
          1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0,
          5'd0, 1'b0, 1'b0, 1'b0};
    bne_i = enc_i(OP_BNE, 5'd1, 5'd3, 16'hFFF1);
    add_i = enc_r(OP_ADD, 5'd0, 5'd1, 5'd2);

    // fields: instr pc | wb wbd wbv | ex exd mw md | fz bt ba |
    //         alu v1 v2 sv pco dst wbo mr mw
    tbl[0]  = '{32'h8001060A, 32'd4, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd6188, 4'h1, 0, 32'd1546, 0, 32'd4, 1, 1, 0, 0};
    tbl[1]  = '{add_i, 32'd8, 1, 1, 32'd5, 0, 0, 0, 0,
                0, 0, 32'd16392, 4'h1, 0, 32'd5, 0, 32'd8, 2, 1, 0, 0};
    tbl[2]  = '{32'h0, 32'd12, 1, 0, 32'd99, 0, 0, 0, 0,
                0, 0, 32'd12, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{enc_r(OP_ADD, 5'd1, 5'd0, 5'd2), 32'd16,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd16400, 4'h1, 32'd5, 0, 0, 32'd16, 2, 1, 0, 0};
    tbl[4]  = '{add_i, 32'd20, 0, 0, 0, 1, 1, 0, 0,
                1, 0, 32'd16404, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{add_i, 32'd20, 0, 0, 0, 0, 0, 1, 1,
                1, 0, 32'd16404, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{add_i, 32'd20, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd16404, 4'h1, 0, 32'd5, 0, 32'd20, 2, 1, 0, 0};
    tbl[7]  = '{32'h0, 32'd24, 1, 1, 32'd3, 0, 0, 0, 0,
                0, 0, 32'd24, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{32'h0, 32'd28, 1, 3, 32'd2, 0, 0, 0, 0,
                0, 0, 32'd28, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{bne_i, 32'd192, 0, 0, 0, 0, 0, 0, 0,
                0, 1, 32'd132, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{32'h0, 32'd32, 1, 3, 32'd3, 0, 0, 0, 0,
                0, 0, 32'd32, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{bne_i, 32'd192, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd132, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{bne_i, 32'd192, 0, 0, 0, 1, 3, 0, 0,
                1, 0, 32'd132, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{32'h0, 32'd36, 1, 1, 32'd1024, 0, 0, 0, 0,
                0, 0, 32'd36, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{32'h0, 32'd40, 1, 2, 32'd7, 0, 0, 0, 0,
                0, 0, 32'd40, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{enc_i(OP_ST, 5'd1, 5'd2, 16'd0), 32'd44,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd44, 4'h1, 32'd1024, 0, 32'd7, 32'd44,
                0, 0, 0, 1};
    tbl[16] = '{enc_i(OP_ST, 5'd1, 5'd2, 16'd0), 32'd44,
                0, 0, 0, 0, 0, 1, 2,
                1, 0, 32'd44, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{enc_i(OP_LD, 5'd1, 5'd6, 16'd8), 32'd48,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd80, 4'h1, 32'd1024, 32'd8, 0, 32'd48,
                6, 1, 1, 0};
    tbl[18] = '{enc_i(OP_SUBI, 5'd2, 5'd7, 16'hFFFF), 32'd52,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd48, 4'h3, 32'd7, 32'hFFFFFFFF, 0, 32'd52,
                7, 1, 0, 0};
    tbl[19] = '{enc_i(OP_JMP, 5'd1, 5'd0, 16'd3), 32'd56,
                0, 0, 0, 1, 1, 0, 0,
                0, 1, 32'd68, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{enc_r(OP_XOR, 5'd1, 5'd2, 5'd8), 32'd60,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd65596, 4'h8, 32'd1024, 32'd7, 0, 32'd60,
                8, 1, 0, 0};
    tbl[21] = '{32'hFC000000, 32'd64, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd64, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{enc_i(OP_BEZ, 5'd3, 5'd0, 16'd2), 32'd68,
                0, 0, 0, 0, 0, 0, 0,
                0, 0, 32'd76, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[23] = '{enc_i(OP_BEZ, 5'd0, 5'd0, 16'hFFFE), 32'd100,
                0, 0, 0, 0, 0, 0, 0,
                0, 1, 32'd92, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0};

    drive(z);
    #2;
    chk("reset freez",    32'(bus.freez),    32'd0);
    chk("reset br_taken", 32'(bus.br_taken), 32'd0);
    chk("reset br_addr",  bus.br_addr,       32'd0);
    chk_regs("reset", z);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d freez", i),    32'(bus.freez),    32'(tbl[i].fz));
      chk($sformatf("v%0d br_taken", i), 32'(bus.br_taken), 32'(tbl[i].bt));
      chk($sformatf("v%0d br_addr", i),  bus.br_addr,       tbl[i].ba);
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), tbl[i]);
    end

    // asynchronous reset mid-stream with a live xor in ID/EXE
    xv = tbl[20];
    @(negedge clk);
    drive(xv);
    @(posedge clk);
    #1;
    chk("pre-rst alu_cmd", 32'(bus.alu_cmd), 32'h8);
    #2;
    rst = 1'b1;
    #1;
    chk_regs("async rst", z);
    @(negedge clk);
    rst = 1'b0;
    xv = z;
    xv.instr = add_i;
    xv.pc = 32'd72;
    drive(xv);
    @(posedge clk);
    #1;
    chk("post-rst R1 val2", bus.val2,         32'd0);
    chk("post-rst dest",    32'(bus.dest),    32'd2);
    chk("post-rst wb_en",   32'(bus.wb_en_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage pipeline. It consumes the IF/ID register outputs (pc = PC+4, instruction).
- Contains the 32x32 register file with the write-back port, RAW hazard detection (no forwarding) and branch resolution.
- Drives freez, br_taken and br_addr back to fetch, and holds the registered ID/EXE pipeline outputs.

Parameters:
- REG_CNT, 32, number of architectural registers; r0 is hardwired to zero.
- DW, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pc_in  in  32  PC+4 from IF/ID
- instr_in  in  32  instruction from IF/ID; 0 = NOP
- wb_en  in  1  write-back enable
- wb_dest  in  5  write-back register
- wb_val  in  32  write-back data
- exe_wb_en  in  1  EXE-stage instruction writes a register
- exe_dest  in  5  EXE-stage destination
- mem_wb_en  in  1  MEM-stage instruction writes a register
- mem_dest  in  5  MEM-stage destination
- freez  out  1  hazard stall to IF (combinational)
- br_taken  out  1  branch/jump taken (combinational)
- br_addr  out  32  branch target (combinational)
- pc_out  out  32  ID/EXE PC
- alu_cmd  out  4  ID/EXE ALU command
- val1  out  32  ID/EXE operand 1
- val2  out  32  ID/EXE operand 2 (register or sign-extended imm)
- st_val  out  32  ID/EXE store data
- dest  out  5  ID/EXE destination
- wb_en_out  out  1  ID/EXE write-back enable
- mem_r  out  1  ID/EXE load
- mem_w  out  1  ID/EXE store

Behaviour:
- Instruction fields:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], sign-extended.
- R-type (add 000001, sub 000011, and 000101, or 000110, nor 000111, xor 001000, sla 001001, sll 001010, sra 001011, srl 001100):
  - val1 = R[rs], val2 = R[rt], dest = rd, wb = 1.
- Immediate:
  - addi 100000, subi 100001: val1 = R[rs], val2 = imm, dest = rt, wb = 1.
  - ld 100100: as addi plus mem_r = 1; ALU command is add.
  - st 100101: val1 = R[rs], val2 = imm, st_val = R[rt], mem_w = 1, wb = 0.
- Branches:
  - bez 101000: taken if R[rs] == 0.
  - bne 101001: taken if R[rs] != R[rt].
  - jmp 101010: always taken.
  - Branch target br_addr = pc_in + (imm << 2). Branches have no wb, mem or ALU effect.
- NOP and unknown opcodes: all control outputs 0.
- ALU command encoding: add 0001, sub 0011, and 0101, or 0110, nor 0111, xor 1000, sla 1001, sll 1010, sra 1011, srl 1100.
- Register file:
  - Write on posedge clk when wb_en and wb_dest != 0.
  - Reads are combinational with write-through: a read of wb_dest during an active write returns wb_val.
  - R[0] always reads 0.
  - rst clears all registers.
- Hazard detection:
  - src1 is used by every non-NOP opcode except jmp.
  - src2 (rt) is used by R-type, st and bne.
  - freez = 1 when a used source is nonzero and equals exe_dest with exe_wb_en, or equals mem_dest with mem_wb_en.
- Branch gating: br_taken = branch condition AND NOT freez. A frozen branch re-evaluates on the next cycle.
- ID/EXE register (posedge clk, async rst):
  - If freez: load a bubble (wb_en_out, mem_r, mem_w, alu_cmd = 0; data fields don't-care, driven 0).
  - Otherwise: load the decoded values.
  - A branch instruction itself passes as a bubble. IF squashes the following instruction.
- Reset values: every output register is 0. freez, br_taken and br_addr follow the reset IF/ID contents (NOP gives 0, 0, pc_in).
- Latency: decoded values appear on the ID/EXE outputs 1 cycle after the instruction is presented.
- A hazard stalls until the producer retires past MEM: at most 2 cycles, since WB write-through resolves the third.

Decomposition:
- Shared package: opcode constants, ALU command constants, field bit positions, NOP encoding.
- Natural sub-module: reg_file (32x32, 2 read ports, 1 write port, write-through, r0 zero).
- Decode, hazard and branch logic plus the ID/EXE register stay in id_stage.

Test Plan:
- Reset, then instr 0x8001060A (addi r1,r0,1546) with no hazards:
  - Next cycle: alu_cmd = 0001, val1 = 0, val2 = 1546, dest = 1, wb_en_out = 1.
  - freez = 0, br_taken = 0.
- Write-through: wb_en = 1, wb_dest = 1, wb_val = 5 in the same cycle as add r2,r0,r1:
  - val2 = 5 latched next cycle.
  - A later write with wb_dest = 0 leaves R0 reading 0.
- Hazard on rt: add r2,r0,r1 with exe_dest = 1, exe_wb_en = 1:
  - freez = 1 and a bubble is latched.
  - exe_wb_en cleared with mem_dest = 1, mem_wb_en = 1: freez stays 1.
  - Both clear: freez = 0 and the add latches.
- bne r1,r3,-15 at pc_in = 192 with R1 = 3, R3 = 2:
  - br_taken = 1, br_addr = 132.
  - With R3 = 3: br_taken = 0.
  - With exe_dest = 3, exe_wb_en = 1: br_taken = 0 because of freez.
- st r2,r1,0 with R1 = 1024, R2 = 7:
  - val1 = 1024, val2 = 0, st_val = 7, mem_w = 1, wb_en_out = 0.
  - mem_dest = 2, mem_wb_en = 1 raises freez.
- Assert rst mid-stream with non-zero outputs:
  - All ID/EXE outputs and registers go to 0 immediately, before the next clock edge.
  - The next read of R1 returns 0.
